srt4_divider: RTL and testbench

- 8-bit unsigned radix-4 SRT divider with serial operand load and serial result unload on shared 8-bit buses.
- Dividend, then divisor, arrive on inbus after a start request; quotient, then remainder, leave on outbus, flagged by endSignal.
- Standalone arithmetic block sitting under a simple bus-driving controller.

---
 rtl/srt4_pkg.sv | 42 ++++
 rtl/srt4_qsel.sv | 19 +
 rtl/srt4_divider.sv | 166 ++++++++++++++++
 tb/tb_srt4_divider.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/srt4_pkg.sv
// Shared types, widths and digit-selection constants for the radix-4 SRT divider.
// Thresholds are in sixteenths of the normalized divisor, indexed by D[6:4].
package srt4_pkg;

    localparam int W_WIDTH    = 21;
    localparam int D_WIDTH    = 8;
    localparam int Q_WIDTH    = 10;
    localparam int ITERATIONS = 5;
    localparam int EST_WIDTH  = 7;
    localparam int EST_LSB    = 12;

    typedef enum logic [3:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        NORM,
        ITER,
        CORR,
        DENORM,
        OUT_Q,
        OUT_R
    } state_t;

    // Estimate >= SEL_GE_x[i] means the digit is at least x; each value sits inside
    // the overlap region of the two neighbouring digits for the whole D[6:4] interval.
    localparam logic signed [EST_WIDTH-1:0] SEL_GE_P2 [0:7] =
        '{7'sd12, 7'sd14, 7'sd16, 7'sd17, 7'sd19, 7'sd20, 7'sd22, 7'sd24};
    localparam logic signed [EST_WIDTH-1:0] SEL_GE_P1 [0:7] =
        '{7'sd4, 7'sd5, 7'sd5, 7'sd6, 7'sd6, 7'sd7, 7'sd7, 7'sd8};
    localparam logic signed [EST_WIDTH-1:0] SEL_GE_Z0 [0:7] =
        '{-7'sd4, -7'sd5, -7'sd5, -7'sd6, -7'sd6, -7'sd7, -7'sd7, -7'sd8};
    localparam logic signed [EST_WIDTH-1:0] SEL_GE_N1 [0:7] =
        '{-7'sd13, -7'sd14, -7'sd16, -7'sd17, -7'sd19, -7'sd20, -7'sd22, -7'sd24};

    function automatic logic [2:0] lead_zeros(input logic [D_WIDTH-1:0] v);
        lead_zeros = 3'd7;
        for (int i = 0; i < D_WIDTH; i++) begin
            if (v[i]) lead_zeros = 3'(D_WIDTH - 1 - i);
        end
    endfunction

endpackage

// File: rtl/srt4_qsel.sv
// Radix-4 quotient digit selection from a truncated partial remainder
// (floor of 4W in sixteenths of the divisor) and the three divisor bits after the leading one.
module srt4_qsel
    import srt4_pkg::*;
(
    input  logic signed [EST_WIDTH-1:0] w_est,
    input  logic        [2:0]           d_idx,
    output logic signed [2:0]           q
);

    always_comb begin
        if (w_est >= SEL_GE_P2[d_idx])      q = 3'sd2;
        else if (w_est >= SEL_GE_P1[d_idx]) q = 3'sd1;
        else if (w_est >= SEL_GE_Z0[d_idx]) q = 3'sd0;
        else if (w_est >= SEL_GE_N1[d_idx]) q = -3'sd1;
        else                                q = -3'sd2;
    end

endmodule

// File: rtl/srt4_divider.sv
// 8-bit unsigned radix-4 SRT divider: operands loaded serially from inbus,
// quotient then remainder driven on outbus with endSignal, fixed 11-cycle latency.
module srt4_divider
    import srt4_pkg::*;
(
    input  logic         clk,
    input  logic         rst_b,
    input  logic         beginSignal,
    input  logic [7:0]   inbus,
    output logic [7:0]   outbus,
    output logic         endSignal
);

    state_t state, state_next;

    logic [2:0]                iter_cnt;
    logic [D_WIDTH-1:0]        x_reg, d_reg, div_norm, rem;
    logic [2:0]                shift, lz;
    logic signed [W_WIDTH-1:0] w, w_next, w_times4, d_multiple;
    logic [W_WIDTH-1:0]        d_scaled;
    logic [Q_WIDTH-1:0]        q_reg, qm_reg, q_next, qm_next;
    logic signed [2:0]         digit;
    logic                      div_zero;
    logic [W_WIDTH-1:0]        w_mag;
    logic [23:0]               w_mag3, w_bound;

    assign div_zero = (d_reg == '0);
    assign lz       = lead_zeros(d_reg);
    assign d_scaled = {3'b000, div_norm, 10'b0};

    srt4_qsel u_qsel (
        .w_est (w[EST_LSB+EST_WIDTH-1:EST_LSB]),
        .d_idx (div_norm[6:4]),
        .q     (digit)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (beginSignal) state_next = LOAD_A;
            LOAD_A:  state_next = LOAD_B;
            LOAD_B:  state_next = NORM;
            NORM:    state_next = ITER;
            ITER:    if (iter_cnt == 3'(ITERATIONS - 1)) state_next = CORR;
            CORR:    state_next = DENORM;
            DENORM:  state_next = OUT_Q;
            OUT_Q:   state_next = OUT_R;
            OUT_R:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Residual recurrence plus on-the-fly conversion: QM always tracks Q-1 so a
    // negative digit never needs a borrow chain.
    always_comb begin
        w_times4   = {w[W_WIDTH-3:0], 2'b00};
        d_multiple = -signed'(d_scaled << 1);
        q_next     = {qm_reg[Q_WIDTH-3:0], 2'd2};
        qm_next    = {qm_reg[Q_WIDTH-3:0], 2'd1};
        case (digit)
            3'sd2: begin
                d_multiple = signed'(d_scaled << 1);
                q_next     = {q_reg[Q_WIDTH-3:0], 2'd2};
                qm_next    = {q_reg[Q_WIDTH-3:0], 2'd1};
            end
            3'sd1: begin
                d_multiple = signed'(d_scaled);
                q_next     = {q_reg[Q_WIDTH-3:0], 2'd1};
                qm_next    = {q_reg[Q_WIDTH-3:0], 2'd0};
            end
            3'sd0: begin
                d_multiple = '0;
                q_next     = {q_reg[Q_WIDTH-3:0], 2'd0};
                qm_next    = {qm_reg[Q_WIDTH-3:0], 2'd3};
            end
            -3'sd1: begin
                d_multiple = -signed'(d_scaled);
                q_next     = {qm_reg[Q_WIDTH-3:0], 2'd3};
                qm_next    = {qm_reg[Q_WIDTH-3:0], 2'd2};
            end
            default: ;
        endcase
        w_next = w_times4 - d_multiple;
    end

    always_ff @(posedge clk) begin
        if (rst_b) begin
            state     <= IDLE;
            iter_cnt  <= '0;
            x_reg     <= '0;
            d_reg     <= '0;
            div_norm  <= '0;
            rem       <= '0;
            shift     <= '0;
            w         <= '0;
            q_reg     <= '0;
            qm_reg    <= '0;
            outbus    <= '0;
            endSignal <= 1'b0;
        end else begin
            state     <= state_next;
            outbus    <= '0;
            endSignal <= 1'b0;
            case (state)
                LOAD_A: x_reg <= inbus;
                LOAD_B: d_reg <= inbus;
                NORM: begin
                    iter_cnt <= '0;
                    q_reg    <= '0;
                    qm_reg   <= '0;
                    if (div_zero) begin
                        shift    <= '0;
                        div_norm <= '0;
                        w        <= '0;
                    end else begin
                        shift    <= lz;
                        div_norm <= d_reg << lz;
                        w        <= W_WIDTH'(x_reg) << lz;
                    end
                end
                ITER: begin
                    iter_cnt <= iter_cnt + 3'd1;
                    if (!div_zero) begin
                        w      <= w_next;
                        q_reg  <= q_next;
                        qm_reg <= qm_next;
                    end
                end
                // The remainder lies in (-D, D), so its low byte is enough for the fix-up.
                CORR: begin
                    if (div_zero) begin
                        q_reg <= Q_WIDTH'(8'hFF);
                        rem   <= x_reg;
                    end else if (w[W_WIDTH-1]) begin
                        q_reg <= qm_reg;
                        rem   <= w[17:10] + div_norm;
                    end else begin
                        rem   <= w[17:10];
                    end
                end
                DENORM: rem <= rem >> shift;
                OUT_Q: begin
                    outbus    <= q_reg[7:0];
                    endSignal <= 1'b1;
                end
                OUT_R: begin
                    outbus    <= rem;
                    endSignal <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign w_mag   = w[W_WIDTH-1] ? -w : w;
    assign w_mag3  = {3'b000, w_mag} * 24'd3;
    assign w_bound = {5'b00000, div_norm, 11'b0};

    always_ff @(posedge clk) begin
        if (!rst_b && !div_zero && (state == ITER || state == CORR))
            assert (w_mag3 <= w_bound);
        if (!rst_b && state == DENORM)
            assert (q_reg[Q_WIDTH-1:8] == 2'b00);
    end

endmodule

// File: tb/tb_srt4_divider.sv
// Self-checking bench for srt4_divider: directed corner cases, abort, back-to-back
// starts and randomized operands checked against plain integer division.
module tb_srt4_divider;

    logic       clk = 1'b0;
    logic       rst_b;
    logic       beginSignal;
    logic [7:0] inbus;
    logic [7:0] outbus;
    logic       endSignal;

    int check_count = 0;
    int fail_count  = 0;

    always #5 clk = ~clk;

    srt4_divider dut (
        .clk         (clk),
        .rst_b       (rst_b),
        .beginSignal (beginSignal),
        .inbus       (inbus),
        .outbus      (outbus),
        .endSignal   (endSignal)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        check_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    function automatic void reference_divide(input int x, input int d,
                                             output logic [7:0] quot, output logic [7:0] rem);
        if (d == 0) begin
            quot = 8'hFF;
            rem  = 8'(x);
        end else begin
            quot = 8'(x / d);
            rem  = 8'(x % d);
        end
    endfunction

    // One full operation; already_started means the previous call's final edge was this
    // operation's start edge, chain_next holds beginSignal high across the return to idle.
    task automatic applyStimulus(input logic [7:0] x, input logic [7:0] d,
                                 input logic chain_next, input logic already_started);
        logic [7:0] exp_q, exp_r;
        reference_divide(int'(x), int'(d), exp_q, exp_r);
        if (!already_started) begin
            beginSignal = 1'b1;
            tick();
        end
        beginSignal = 1'b0;
        inbus = x;
        tick();
        inbus = d;
        tick();
        inbus = 8'($urandom);
        for (int e = 3; e <= 10; e++) tick();
        checkOutput("busy_end", 8'(endSignal), 8'd0);
        tick();
        checkOutput($sformatf("quot %0d/%0d", x, d), outbus, exp_q);
        checkOutput("end_q", 8'(endSignal), 8'd1);
        tick();
        checkOutput($sformatf("rem %0d/%0d", x, d), outbus, exp_r);
        checkOutput("end_r", 8'(endSignal), 8'd1);
        beginSignal = chain_next;
        tick();
        checkOutput("idle_out", outbus, 8'd0);
        checkOutput("idle_end", 8'(endSignal), 8'd0);
        beginSignal = 1'b0;
    endtask

    initial begin
        int         dir_x [0:5];
        int         dir_d [0:5];
        logic [7:0] rx, rd;
        logic       chain, started;

        dir_x = '{255, 0, 7, 255, 42, 1};
        dir_d = '{1, 7, 255, 128, 0, 255};

        rst_b       = 1'b1;
        beginSignal = 1'b0;
        inbus       = 8'd0;
        tick();
        tick();
        checkOutput("reset_out", outbus, 8'd0);
        checkOutput("reset_end", 8'(endSignal), 8'd0);
        rst_b = 1'b0;
        tick();

        applyStimulus(8'd101, 8'd5, 1'b0, 1'b0);
        for (int i = 0; i <= 5; i++)
            applyStimulus(8'(dir_x[i]), 8'(dir_d[i]), 1'b0, 1'b0);

        // Abort at E6, then make sure no result pulse leaks out.
        beginSignal = 1'b1;
        tick();
        beginSignal = 1'b0;
        inbus = 8'd200;
        tick();
        inbus = 8'd3;
        tick();
        repeat (3) tick();
        rst_b = 1'b1;
        tick();
        checkOutput("abort_out", outbus, 8'd0);
        checkOutput("abort_end", 8'(endSignal), 8'd0);
        rst_b = 1'b0;
        for (int c = 0; c < 12; c++) begin
            tick();
            checkOutput("abort_quiet_end", 8'(endSignal), 8'd0);
            checkOutput("abort_quiet_out", outbus, 8'd0);
        end
        applyStimulus(8'd200, 8'd3, 1'b0, 1'b0);

        applyStimulus(8'd77, 8'd9, 1'b1, 1'b0);
        applyStimulus(8'd250, 8'd13, 1'b0, 1'b1);

        started = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            rx = 8'($urandom_range(0, 255));
            case ($urandom_range(0, 7))
                0:       rd = 8'd0;
                1:       rd = 8'($urandom_range(1, 8));
                2:       rd = 8'(1 << $urandom_range(0, 7));
                default: rd = 8'($urandom_range(1, 255));
            endcase
            chain = (n != 1499) && ($urandom_range(0, 3) == 0);
            applyStimulus(rx, rd, chain, started);
            started = chain;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
        $finish;
    end

endmodule
